// File: rtl/alu_sequencer_if.sv
// Handshake, operand/result and full-adder cell signals for alu_sequencer.
// The master side is the switch/key logic together with the external adder cell.
interface alu_sequencer_if #(parameter int N = 4);
  logic           start;
  logic [2:0]     op;
  logic [N-1:0]   data_a;
  logic [N-1:0]   data_b;
  logic           fa_a;
  logic           fa_b;
  logic           fa_ci;
  logic           fa_s;
  logic           fa_co;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;

  modport master (
    output start, op, data_a, data_b, fa_s, fa_co,
    input  fa_a, fa_b, fa_ci, busy, done, result
  );

  modport slave (
    input  start, op, data_a, data_b, fa_s, fa_co,
    output fa_a, fa_b, fa_ci, busy, done, result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: bit-serial add through an external full-adder cell,
// single-cycle logic/concat/accumulate ops, and ownership of the result register.
module alu_sequencer #(
  parameter int N = 4
) (
  input logic            clock,
  input logic            resetn,
  alu_sequencer_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD      = 3'b000;
  localparam logic [2:0] OP_NAND_NOR = 3'b001;
  localparam logic [2:0] OP_CONCAT   = 3'b010;
  localparam logic [2:0] OP_XOR_XNOR = 3'b011;
  localparam logic [2:0] OP_ACCUM    = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg,  state_next;
  logic [N-1:0]   a_reg,      a_next;
  logic [N-1:0]   b_reg,      b_next;
  logic [2:0]     op_reg,     op_next;
  logic [IW-1:0]  idx_reg,    idx_next;
  logic           carry_reg,  carry_next;
  logic [N-1:0]   sum_reg,    sum_next;
  logic [2*N-1:0] result_reg, result_next;

  logic           add_active;
  logic [N-1:0]   sum_merge;

  assign add_active = (state_reg == EXEC) && (op_reg == OP_ADD);

  // Shadow sum with the current cell output folded in, so the final bit lands in result directly.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_sum_merge
      assign sum_merge[gi] = (idx_reg == IW'(gi)) ? bus.fa_s : sum_reg[gi];
    end
  endgenerate

  assign bus.fa_a   = add_active & a_reg[idx_reg];
  assign bus.fa_b   = add_active & b_reg[idx_reg];
  assign bus.fa_ci  = add_active & carry_reg;
  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = (state_reg == DONE);
  assign bus.result = result_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      sum_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      sum_reg    <= sum_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    idx_next    = idx_reg;
    carry_next  = carry_reg;
    sum_next    = sum_reg;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          a_next     = bus.data_a;
          b_next     = bus.data_b;
          op_next    = bus.op;
          idx_next   = '0;
          carry_next = 1'b0;
          sum_next   = '0;
          state_next = EXEC;
        end
      end

      EXEC: begin
        if (op_reg == OP_ADD) begin
          sum_next   = sum_merge;
          carry_next = bus.fa_co;
          if (idx_reg == IW'(N - 1)) begin
            result_next = (2*N)'({bus.fa_co, sum_merge});
            state_next  = DONE;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end else begin
          state_next = DONE;
          case (op_reg)
            OP_NAND_NOR: result_next = {~(a_reg & b_reg), ~(a_reg | b_reg)};
            OP_CONCAT:   result_next = {a_reg, b_reg};
            OP_XOR_XNOR: result_next = {a_reg ^ b_reg, a_reg ~^ b_reg};
            OP_ACCUM:    result_next = result_reg + {a_reg, b_reg};
            default:     result_next = '0;
          endcase
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table plus hand-written
// sequences for input toggling during busy and asynchronous mid-operation reset.
module tb_alu_sequencer;
  localparam int N = 4;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  alu_sequencer_if #(.N(N)) bus ();

  alu_sequencer #(.N(N)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  // Ideal full-adder cell
  assign bus.fa_s  = bus.fa_a ^ bus.fa_b ^ bus.fa_ci;
  assign bus.fa_co = (bus.fa_a & bus.fa_b) | (bus.fa_ci & (bus.fa_a ^ bus.fa_b));

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;

  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] mon_exp;

  typedef struct {
    logic [2:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clock) begin
    if (resetn && bus.done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got result %0h, expected no pending op", bus.result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 16'(bus.result), 16'(mon_exp));
        $display("op done: result=%h expected=%h", bus.result, mon_exp);
      end
    end
  end

  task automatic wait_idle();
    @(negedge clock);
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clock);
    if (bus.busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=1, expected 0");
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic run_op(input logic [2:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [2*N-1:0] exp);
    int   lat;
    int   k;
    logic carry;
    logic got;
    wait_idle();
    bus.start  = 1'b1;
    bus.op     = op;
    bus.data_a = a;
    bus.data_b = b;
    exp_q.push_back(exp);
    @(posedge clock);
    #1 bus.start = 1'b0;
    lat   = 1;
    k     = 0;
    carry = 1'b0;
    got   = 1'b0;
    while (lat < 20 && !got) begin
      @(negedge clock);
      if (bus.done) begin
        got = 1'b1;
      end else if (op == 3'b000 && k < N) begin
        check("fa_a", 16'(bus.fa_a), 16'(a[k]));
        check("fa_b", 16'(bus.fa_b), 16'(b[k]));
        check("fa_ci", 16'(bus.fa_ci), 16'(carry));
        carry = (a[k] & b[k]) | (carry & (a[k] ^ b[k]));
        k++;
      end else begin
        check("fa_quiet", 16'({bus.fa_a, bus.fa_b, bus.fa_ci}), 16'(0));
      end
      if (!got) begin
        @(posedge clock);
        lat++;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, expected done for op %0d", op);
    end else begin
      check("latency", 16'(lat), (op == 3'b000) ? 16'(N + 1) : 16'(2));
    end
  endtask

  initial begin
    int d0;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.data_a = '0;
    bus.data_b = '0;

    tbl[0]  = '{3'b100, 4'h8, 4'h0, 8'h80};
    tbl[1]  = '{3'b100, 4'h8, 4'h0, 8'h00};
    tbl[2]  = '{3'b100, 4'h0, 4'h5, 8'h05};
    tbl[3]  = '{3'b111, 4'hF, 4'hF, 8'h00};
    tbl[4]  = '{3'b001, 4'hC, 4'hA, 8'h71};
    tbl[5]  = '{3'b011, 4'h5, 4'h3, 8'h69};
    tbl[6]  = '{3'b010, 4'hA, 4'h5, 8'hA5};
    tbl[7]  = '{3'b000, 4'h3, 4'h4, 8'h07};
    tbl[8]  = '{3'b000, 4'h9, 4'h9, 8'h12};
    tbl[9]  = '{3'b000, 4'hF, 4'hF, 8'h1E};
    tbl[10] = '{3'b100, 4'h1, 4'h2, 8'h30};
    tbl[11] = '{3'b100, 4'hF, 4'hF, 8'h2F};

    #12;
    check("rst_busy", 16'(bus.busy), 16'(0));
    check("rst_done", 16'(bus.done), 16'(0));
    check("rst_result", 16'(bus.result), 16'(0));
    check("rst_fa", 16'({bus.fa_a, bus.fa_b, bus.fa_ci}), 16'(0));
    @(negedge clock);
    resetn = 1'b1;

    run_op(3'b000, 4'hF, 4'h1, 8'h10);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    // Inputs toggled every cycle while busy must not disturb the add or retrigger
    wait_idle();
    bus.start  = 1'b1;
    bus.op     = 3'b000;
    bus.data_a = 4'h3;
    bus.data_b = 4'h4;
    exp_q.push_back(8'h07);
    d0 = done_count;
    @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!bus.busy) break;
      bus.start  = ~bus.start;
      bus.data_a = 4'($urandom);
      bus.data_b = 4'($urandom);
      bus.op     = 3'($urandom);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("no_reaccept", 16'(bus.busy), 16'(0));
    check("done_pulses", 16'(done_count - d0), 16'(1));

    // Asynchronous reset at bit 2 of a serial add
    wait_idle();
    bus.start  = 1'b1;
    bus.op     = 3'b000;
    bus.data_a = 4'h3;
    bus.data_b = 4'h4;
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("pre_rst_fa_b", 16'(bus.fa_b), 16'(1));
    check("pre_rst_result", 16'(bus.result), 16'(8'h07));
    resetn = 1'b0;
    #1;
    check("arst_busy", 16'(bus.busy), 16'(0));
    check("arst_done", 16'(bus.done), 16'(0));
    check("arst_result", 16'(bus.result), 16'(0));
    check("arst_fa", 16'({bus.fa_a, bus.fa_b, bus.fa_ci}), 16'(0));
    @(negedge clock);
    resetn = 1'b1;
    exp_q.delete();
    run_op(3'b010, 4'hA, 4'h5, 8'hA5);

    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_results: got %0d left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
